load_unit: RTL
==============

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width (32 or 64; RAM word is always 32 bits).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning RAM word-address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum wait cycles for iRAM_READY (1..255).
REQ-004 SHALL have ports iCLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have ports iRST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports iSTART  in  1  request pulse; sampled only when oBUSY=0.
REQ-007 SHALL have ports iIR  in  32  instruction word, sampled with iSTART.
REQ-008 SHALL have ports iREG_OUT1  in  XLEN  rs1 value, sampled with iSTART.
REQ-009 SHALL have ports oBUSY  out  1  high in any state other than IDLE.
REQ-010 SHALL have ports oDONE  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports oRD  out  5  destination register latched from iIR[11:7].
REQ-012 SHALL have ports oREG_IN  out  XLEN  load result; valid when oDONE=1.
REQ-013 SHALL have ports oREG_WE  out  1  register write enable; only ever high together with oDONE.
REQ-014 SHALL have ports oFAULT  out  1  error flag; only ever high together with oDONE.
REQ-015 SHALL have ports oRAM_CE, oRAM_RD  out  1 each  RAM request strobes.
REQ-016 SHALL have ports oRAM_ADDR  out  ADDR_W  word address = effective address >> 2.
REQ-017 SHALL have ports iRAM_DATA  in  32  RAM read word; iRAM_READY  in  1  data-valid handshake.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RESP; RESP lasts exactly one cycle.
REQ-019 SHALL, in IDLE with iSTART=1, latch rd, func3 and EA = iREG_OUT1 + sign-extended iIR[31:20] (XLEN bits, wrap-around modulo 2^XLEN).
REQ-020 SHALL then enter REQ, unless the request is faulty (REQ-025/026), in which case it SHALL enter RESP directly.
REQ-021 SHALL hold oRAM_CE=oRAM_RD=1 and oRAM_ADDR=EA[ADDR_W+1:2] stable for every cycle in REQ, and SHALL hold them at 0 in every other state.
REQ-022 SHALL, in REQ, capture iRAM_DATA on the first cycle iRAM_READY=1 and enter RESP; minimum latency is iSTART at cycle 0, RAM request at cycle 1, oDONE at cycle 2.
REQ-023 SHALL count REQ cycles without iRAM_READY; when TIMEOUT cycles have elapsed it SHALL enter RESP with fault.
REQ-024 SHALL select the extracted data by func3 and EA[1:0]:
- 0 LB: byte EA[1:0], sign-extended to XLEN.
- 1 LH: half EA[1], sign-extended.
- 2 LW: full word, sign-extended when XLEN=64.
- 4 LBU: byte, zero-extended.
- 5 LHU: half, zero-extended.
- 6 LWU: legal only when XLEN=64, zero-extended.
REQ-025 SHALL treat as faulty: iIR[6:0] != 7'b0000011; func3 3 or 7; func3 6 when XLEN=32.
REQ-026 SHALL treat as faulty any misaligned access: halfword with EA[0]=1; word with EA[1:0] != 0.
REQ-027 SHALL, in RESP, assert oDONE=1 and oREG_IN=result, then return to IDLE.
- oREG_WE=1 only if there is no fault and rd != 0.
- On any fault: oFAULT=1, oREG_WE=0, oREG_IN=0.
REQ-028 SHALL ignore iSTART while oBUSY=1; iIR and iREG_OUT1 changes after the latch SHALL have no effect.
REQ-029 SHALL accept a new iSTART in the cycle immediately after RESP, giving back-to-back throughput of one load per 3 cycles at zero wait.
REQ-030 SHALL ignore iRAM_READY outside REQ.

Reset
REQ-031 SHALL, while iRST=1 at any time including mid-transaction, force state IDLE, the timeout counter to 0 and all outputs to 0, without waiting for a clock edge.
REQ-032 SHALL NOT produce oDONE for a transaction aborted by reset.

Verification
REQ-033 Scenario LW: rs1=0x10, imm=0x004, RAM[5]=0xDEADBEEF, READY at cycle 1 -> oRAM_ADDR=5 at cycle 1; oDONE, oREG_WE=1, oREG_IN=0xDEADBEEF at cycle 2.
REQ-034 Scenario LB/LBU: EA=0x13, RAM[4]=0x80FF1234 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
REQ-035 Scenario LH negative immediate: rs1=0x20, imm=0xFFE, RAM[7]=0x8001xxxx -> EA=0x1E, oREG_IN=0xFFFF8001.
REQ-036 Scenario misaligned LW: EA=0x06 -> no RAM strobe; oDONE, oFAULT=1, oREG_WE=0 at cycle 1.
REQ-037 Scenario timeout: iRAM_READY held 0 -> oRAM_CE high for exactly TIMEOUT cycles, then oDONE with oFAULT=1.
REQ-038 Scenario reset mid-REQ: assert iRST in the 2nd wait cycle -> oRAM_CE=0 immediately, no oDONE; a fresh LW after release completes normally.

Source files
------------

// File: rtl/load_unit.sv
// Load unit: computes rs1+imm, issues a single RAM word read, then extracts and extends the
// addressed byte/half/word. Faulty requests and RAM timeouts complete with oFAULT instead.
module load_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic [31:0]       iIR,
    input  logic [XLEN-1:0]   iREG_OUT1,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [4:0]        oRD,
    output logic [XLEN-1:0]   oREG_IN,
    output logic              oREG_WE,
    output logic              oFAULT,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    input  logic [31:0]       iRAM_DATA,
    input  logic              iRAM_READY
);

    localparam int unsigned EaW = ADDR_W + 2;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        func3_q, func3_d;
    logic [EaW-1:0]    ea_q, ea_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              fault_q, fault_d;

    // The rs1 field of the instruction is irrelevant here.
    logic unused_ir;
    assign unused_ir = ^iIR[19:15];

    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    extract = XLEN'($signed(b));
            3'd1:    extract = XLEN'($signed(h));
            3'd2:    extract = XLEN'($signed(w));
            3'd4:    extract = XLEN'(b);
            3'd5:    extract = XLEN'(h);
            3'd6:    extract = XLEN'(w);
            default: extract = '0;
        endcase
    endfunction

    function automatic logic bad_request(input logic [31:0] ir, input logic [1:0] off);
        logic [2:0] f3;
        f3 = ir[14:12];
        bad_request = (ir[6:0] != 7'b0000011) || (f3 == 3'd3) || (f3 == 3'd7) ||
                      ((f3 == 3'd6) && (XLEN == 32)) ||
                      ((f3[1:0] == 2'b01) && off[0]) ||
                      ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= StIdle;
            rd_q     <= '0;
            func3_q  <= '0;
            ea_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            func3_q  <= func3_d;
            ea_q     <= ea_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        func3_d  = func3_q;
        ea_d     = ea_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        fault_d  = fault_q;
        case (state_q)
            StIdle: begin
                if (iSTART) begin
                    rd_d     = iIR[11:7];
                    func3_d  = iIR[14:12];
                    // Only the word address and byte offset of the effective address are kept.
                    ea_d     = EaW'(iREG_OUT1 + XLEN'($signed(iIR[31:20])));
                    cnt_d    = '0;
                    result_d = '0;
                    fault_d  = bad_request(iIR, ea_d[1:0]);
                    state_d  = fault_d ? StResp : StReq;
                end
            end
            StReq: begin
                if (iRAM_READY) begin
                    result_d = extract(func3_q, ea_q[1:0], iRAM_DATA);
                    state_d  = StResp;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oBUSY     = (state_q != StIdle);
        oDONE     = (state_q == StResp);
        oRAM_CE   = (state_q == StReq);
        oRAM_RD   = (state_q == StReq);
        oRAM_ADDR = (state_q == StReq) ? ea_q[EaW-1:2] : '0;
        oRD       = rd_q;
        oFAULT    = oDONE && fault_q;
        oREG_WE   = oDONE && !fault_q && (rd_q != 5'd0);
        oREG_IN   = (oDONE && !fault_q) ? result_q : '0;
    end

endmodule
